// File: rtl/buf_pipeline_param_pkg.sv
// Shared widths, control-bundle bit positions and helpers for the elastic
// pipeline register chain that sits between ID and WB.
package buf_pipeline_param_pkg;

  localparam int ANCHO_DATOS_DEF = 32;
  localparam int ANCHO_CTRL_DEF  = 8;
  localparam int ANCHO_REG_DEF   = 5;
  localparam int ETAPAS_DEF      = 3;

  // Bit positions inside the control bundle carried alongside the payload.
  localparam int CTRL_ALU_OP_LSB   = 0;
  localparam int CTRL_ALU_OP_W     = 4;
  localparam int CTRL_MEM_ESCRIBIR = 4;
  localparam int CTRL_MEM_LEER     = 5;
  localparam int CTRL_MEM_A_REG    = 6;
  localparam int CTRL_ALU_SRC      = 7;

  localparam int REG_CERO = 0;
  localparam int ANCHO_CNT = 16;

  typedef logic [ANCHO_CNT-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/buf_pipeline_param_etapa.sv
// One elastic stage: a valid bit plus a payload register. Loads from upstream
// when allowed to, holds otherwise; flush clears the valid bit over any load.
module buf_pipeline_param_etapa #(
  parameter int ANCHO = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_carga,
  input  logic             i_flush,
  input  logic             i_valido,
  input  logic [ANCHO-1:0] i_datos,
  output logic             o_valido,
  output logic [ANCHO-1:0] o_datos
);

  logic             r_valido;
  logic [ANCHO-1:0] r_datos;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valido <= 1'b0;
      r_datos  <= '0;
    end else begin
      if (i_flush)
        r_valido <= 1'b0;
      else if (i_carga)
        r_valido <= i_valido;
      // Payload only moves with a real item, so an emptied stage keeps stale data.
      if (i_carga && i_valido)
        r_datos <= i_datos;
    end
  end

  assign o_valido = r_valido;
  assign o_datos  = r_datos;

endmodule

// File: rtl/buf_pipeline_param.sv
// Parametrised elastic pipeline register chain (ID..WB) with per-stage flush,
// load-use bubble insertion and per-stage dest/valid taps for forwarding.
module buf_pipeline_param
  import buf_pipeline_param_pkg::*;
#(
  parameter int ANCHO_DATOS = ANCHO_DATOS_DEF,
  parameter int ANCHO_CTRL  = ANCHO_CTRL_DEF,
  parameter int ANCHO_REG   = ANCHO_REG_DEF,
  parameter int ETAPAS      = ETAPAS_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valido,
  output logic                        in_listo,
  input  logic [ANCHO_DATOS-1:0]      in_datos,
  input  logic [ANCHO_CTRL-1:0]       in_ctrl,
  input  logic [ANCHO_REG-1:0]        in_dest,
  input  logic                        in_escribe,
  input  logic                        in_lee_mem,
  input  logic [ANCHO_REG-1:0]        in_rs,
  input  logic [ANCHO_REG-1:0]        in_rt,
  input  logic [ETAPAS-1:0]           flush,
  output logic                        out_valido,
  input  logic                        out_listo,
  output logic [ANCHO_DATOS-1:0]      out_datos,
  output logic [ANCHO_CTRL-1:0]       out_ctrl,
  output logic [ANCHO_REG-1:0]        out_dest,
  output logic                        out_escribe,
  output logic [ETAPAS-1:0]           etapa_valido,
  output logic [ETAPAS*ANCHO_REG-1:0] etapa_dest,
  output logic [ETAPAS-1:0]           etapa_escribe,
  output logic                        burbuja,
  output logic [ANCHO_CNT-1:0]        cnt_burbujas
);

  // Handshake: an item moves across a boundary only in a cycle where the sender's
  // valid and the receiver's ready (listo) are both high; ready may depend
  // combinationally on downstream ready, valid never depends on ready.

  localparam int P_CTRL = ANCHO_DATOS;
  localparam int P_DEST = P_CTRL + ANCHO_CTRL;
  localparam int P_LEE  = P_DEST + ANCHO_REG;
  localparam int P_ESC  = P_LEE + 1;
  localparam int AP     = P_ESC + 1;

  logic [AP-1:0]        w_in_pack;
  logic [AP-1:0]        w_pay [ETAPAS];
  logic [ETAPAS-1:0]    w_valido;
  logic [ETAPAS:0]      w_listo;
  logic                 w_in_val0;
  logic                 w_haz;
  logic [ANCHO_REG-1:0] w_dest0;
  logic                 w_lee0;
  logic                 w_esc0;
  logic                 w_unused_lee;
  cnt_t                 r_cnt_burbujas;

  // A write to register zero is meaningless, so it is dropped at entry.
  assign w_in_pack = {in_escribe && (in_dest != ANCHO_REG'(REG_CERO)),
                      in_lee_mem, in_dest, in_ctrl, in_datos};

  // A flushed stage counts as empty, letting upstream advance into it.
  always_comb begin
    w_listo         = '0;
    w_listo[ETAPAS] = out_listo;
    for (int i = ETAPAS - 1; i >= 0; i--)
      w_listo[i] = !w_valido[i] || w_listo[i+1] || flush[i];
  end

  assign w_dest0 = w_pay[0][P_DEST +: ANCHO_REG];
  assign w_lee0  = w_pay[0][P_LEE];
  assign w_esc0  = w_pay[0][P_ESC];

  assign w_haz = in_valido && w_valido[0] && w_lee0 && w_esc0 &&
                 (w_dest0 != ANCHO_REG'(REG_CERO)) &&
                 ((w_dest0 == in_rs) || (w_dest0 == in_rt));

  assign in_listo  = w_listo[0] && !w_haz;
  assign burbuja   = w_haz && w_listo[0];
  assign w_in_val0 = in_valido && !w_haz;

  for (genvar g = 0; g < ETAPAS; g++) begin : g_etapa
    if (g == 0) begin : g_primera
      buf_pipeline_param_etapa #(.ANCHO(AP)) u_etapa (
        .clk      (clk),
        .reset    (reset),
        .i_carga  (w_listo[g]),
        .i_flush  (flush[g]),
        .i_valido (w_in_val0),
        .i_datos  (w_in_pack),
        .o_valido (w_valido[g]),
        .o_datos  (w_pay[g])
      );
    end else begin : g_resto
      buf_pipeline_param_etapa #(.ANCHO(AP)) u_etapa (
        .clk      (clk),
        .reset    (reset),
        .i_carga  (w_listo[g]),
        .i_flush  (flush[g]),
        .i_valido (w_valido[g-1]),
        .i_datos  (w_pay[g-1]),
        .o_valido (w_valido[g]),
        .o_datos  (w_pay[g])
      );
    end
    assign etapa_dest[g*ANCHO_REG +: ANCHO_REG] = w_pay[g][P_DEST +: ANCHO_REG];
    assign etapa_escribe[g] = w_valido[g] && w_pay[g][P_ESC];
  end

  assign etapa_valido = w_valido;

  assign out_valido   = w_valido[ETAPAS-1];
  assign out_datos    = w_pay[ETAPAS-1][0 +: ANCHO_DATOS];
  assign out_ctrl     = w_pay[ETAPAS-1][P_CTRL +: ANCHO_CTRL];
  assign out_dest     = w_pay[ETAPAS-1][P_DEST +: ANCHO_REG];
  assign out_escribe  = w_valido[ETAPAS-1] && w_pay[ETAPAS-1][P_ESC];
  assign w_unused_lee = w_pay[ETAPAS-1][P_LEE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt_burbujas <= '0;
    else if (burbuja)
      r_cnt_burbujas <= sat_inc(r_cnt_burbujas);
  end

  assign cnt_burbujas = r_cnt_burbujas;

endmodule
